// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared half-width adder; each add/sub
// runs low half then high half, so one operation completes every 3 cycles.
module adder_arbiter #(
  parameter  int N = 16,
  parameter  int R = 4,
  localparam int W = (R > 2) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   sub,
  input  logic [R*N-1:0] op_a,
  input  logic [R*N-1:0] op_b,
  output logic [R-1:0]   grant,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   res_id,
  output logic [N-1:0]   result,
  output logic           carry,
  output logic           overflow,
  output logic           negative
);
  localparam int H = N / 2;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic [W-1:0] id;
  } op_t;

  state_t               state, nstate;
  op_t                  cur;
  logic [W-1:0]         ptr, win, nptr;
  logic [W:0]           pos;
  logic                 found, take;
  logic [R-1:0][N-1:0]  a_arr, b_arr;
  logic [H-1:0]         lo, sum_h;
  logic                 mid_carry;

  assign a_arr = op_a;
  assign b_arr = op_b;

  // Search starts at ptr and wraps modulo R; first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int k = 0; k < R; k++) begin
      pos = {1'b0, ptr} + (W+1)'(k);
      if (pos >= (W+1)'(R)) pos = pos - (W+1)'(R);
      if (!found && req[pos[W-1:0]]) begin
        found = 1'b1;
        win   = pos[W-1:0];
      end
    end
  end

  assign nptr = (win == W'(R-1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    take   = 1'b0;
    grant  = '0;
    unique case (state)
      IDLE: if (found && !rst) begin
        take       = 1'b1;
        grant[win] = 1'b1;
        nstate     = LOW;
      end
      LOW:     nstate = HIGH;
      HIGH:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Shared half adder, split below its MSB so the carry into the top bit
  // is visible for signed overflow in the HIGH pass.
  logic [N-1:0] bx;
  logic [H-1:0] ha, hb, part;
  logic [1:0]   top;
  logic         hc, cout, c_msb;

  assign bx = cur.sub ? ~cur.b : cur.b;

  always_comb begin
    if (state == HIGH) begin
      ha = cur.a[N-1:H];
      hb = bx[N-1:H];
      hc = mid_carry;
    end else begin
      ha = cur.a[H-1:0];
      hb = bx[H-1:0];
      hc = cur.sub;
    end
  end

  assign part  = {1'b0, ha[H-2:0]} + {1'b0, hb[H-2:0]} + H'(hc);
  assign top   = {1'b0, ha[H-1]} + {1'b0, hb[H-1]} + {1'b0, part[H-1]};
  assign sum_h = {top[0], part[H-2:0]};
  assign cout  = top[1];
  assign c_msb = part[H-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      ptr       <= '0;
      lo        <= '0;
      mid_carry <= 1'b0;
      done      <= 1'b0;
      res_id    <= '0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (take) begin
          cur.a   <= a_arr[win];
          cur.b   <= b_arr[win];
          cur.sub <= sub[win];
          cur.id  <= win;
          ptr     <= nptr;
        end
        LOW: begin
          lo        <= sum_h;
          mid_carry <= cout;
        end
        HIGH: begin
          result   <= {sum_h, lo};
          carry    <= cout;
          overflow <= c_msb ^ cout;
          negative <= c_msb ^ cout ^ sum_h[H-1];
          res_id   <= cur.id;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
